// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory. Packs bytes big-endian into
// 32-bit words, writes them from word address 0 and holds the ifu until done.
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              byte_last,
    output logic              byte_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [1:0]        b_reg;
    logic [ADDR_W:0]   count_reg;
    logic              err_reg;
    logic              last_reg;

    logic load_start;
    logic xfer;
    logic word_end;
    logic addr_top;

    // start only has effect from a resting state; it is ignored mid-load
    assign load_start = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
    assign xfer       = byte_valid && (state_reg == S_COLLECT);
    assign word_end   = xfer && ((b_reg == 2'd3) || byte_last);
    assign addr_top   = (addr_reg == {ADDR_W{1'b1}});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (word_end) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (last_reg || addr_top) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_COLLECT;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_next = S_COLLECT;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Decoded straight from the state register so an async reset drops them at once
    always_comb begin
        byte_ready = 1'b0;
        im_we      = 1'b0;
        cpu_hold   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            S_COLLECT: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                busy       = 1'b1;
            end
            S_WRITE: begin
                im_we    = 1'b1;
                cpu_hold = 1'b1;
                busy     = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                byte_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_reg  <= '0;
            b_reg     <= '0;
            count_reg <= '0;
            err_reg   <= 1'b0;
            last_reg  <= 1'b0;
        end else if (load_start) begin
            addr_reg  <= '0;
            b_reg     <= '0;
            count_reg <= '0;
            err_reg   <= 1'b0;
            last_reg  <= 1'b0;
        end else if (xfer) begin
            b_reg    <= b_reg + 2'd1;
            last_reg <= byte_last;
            if (byte_last && (b_reg != 2'd3)) begin
                err_reg <= 1'b1;
            end
        end else if (state_reg == S_WRITE) begin
            count_reg <= count_reg + (ADDR_W+1)'(1);
            b_reg     <= '0;
            // overflow stops at the top address instead of wrapping
            if (!last_reg) begin
                if (addr_top) begin
                    err_reg <= 1'b1;
                end else begin
                    addr_reg <= addr_reg + ADDR_W'(1);
                end
            end
        end
    end

    // One register per byte lane; lane 0 is the first byte of the word (bits 31:24)
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_reg;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                lane_reg <= '0;
            end else if (load_start || (state_reg == S_WRITE)) begin
                lane_reg <= '0;
            end else if (xfer && (b_reg == 2'(gi))) begin
                lane_reg <= byte_data;
            end
        end

        assign im_wdata[31-8*gi -: 8] = lane_reg;
    end

    assign im_addr    = addr_reg;
    assign word_count = count_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a default-size instance for the main loads and
// a 4-word instance for the overflow case, with a write-capturing memory model.
module tb_imem_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_a, vld_a, start_b, vld_b;
    logic [7:0] bdata;
    logic       blast;

    logic        rdy_a, we_a, hold_a, busy_a, done_a, err_a;
    logic [9:0]  addr_a;
    logic [31:0] wdata_a;
    logic [10:0] cnt_a;

    logic        rdy_b, we_b, hold_b, busy_b, done_b, err_b;
    logic [1:0]  addr_b;
    logic [31:0] wdata_b;
    logic [2:0]  cnt_b;

    imem_loader #(.ADDR_W(10)) dut_a (
        .clk(clk), .reset(rst_n), .start(start_a), .byte_valid(vld_a),
        .byte_data(bdata), .byte_last(blast), .byte_ready(rdy_a), .im_we(we_a),
        .im_addr(addr_a), .im_wdata(wdata_a), .cpu_hold(hold_a), .busy(busy_a),
        .done(done_a), .word_count(cnt_a), .err(err_a)
    );

    imem_loader #(.ADDR_W(2)) dut_b (
        .clk(clk), .reset(rst_n), .start(start_b), .byte_valid(vld_b),
        .byte_data(bdata), .byte_last(blast), .byte_ready(rdy_b), .im_we(we_b),
        .im_addr(addr_b), .im_wdata(wdata_b), .cpu_hold(hold_b), .busy(busy_b),
        .done(done_b), .word_count(cnt_b), .err(err_b)
    );

    logic [31:0] im_a [1024];
    logic [31:0] im_b [4];
    int          nwr_a = 0;
    int          nwr_b = 0;
    logic [9:0]  last_addr_a = '0;

    always @(posedge clk) begin
        if (we_a) begin
            im_a[addr_a] = wdata_a;
            last_addr_a  = addr_a;
            nwr_a++;
            $display("write A: addr=%0d data=0x%08h", addr_a, wdata_a);
        end
        if (we_b) begin
            im_b[addr_b] = wdata_b;
            nwr_b++;
            $display("write B: addr=%0d data=0x%08h", addr_b, wdata_b);
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Presents one byte and returns on the negedge after it was accepted
    task automatic send_byte(input bit sel, input logic [7:0] d, input bit l, input bit gap);
        int t = 0;
        bdata = d;
        blast = l;
        if (sel) vld_b = 1'b1; else vld_a = 1'b1;
        while (!(sel ? rdy_b : rdy_a) && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!(sel ? rdy_b : rdy_a)) begin
            check("ready_timeout", 32'(sel ? rdy_b : rdy_a), 32'd1);
        end else begin
            @(negedge clk);
        end
        if (gap) begin
            vld_a = 1'b0;
            vld_b = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input bit sel);
        int t = 0;
        while (!(sel ? done_b : done_a) && t < 30) begin
            @(negedge clk);
            t++;
        end
        check(sel ? "done_b" : "done_a", 32'(sel ? done_b : done_a), 32'd1);
    endtask

    localparam logic [7:0] S1 [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h3C, 8'h09, 8'h12, 8'h34};
    localparam logic [7:0] S3 [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int rc;
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        vld_a   = 1'b0;
        vld_b   = 1'b0;
        bdata   = '0;
        blast   = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_ready", 32'(rdy_a), 32'd0);
        check("rst_we",    32'(we_a), 32'd0);
        check("rst_addr",  32'(addr_a), 32'd0);
        check("rst_wdata", wdata_a, 32'd0);
        check("rst_hold",  32'(hold_a), 32'd0);
        check("rst_busy",  32'(busy_a), 32'd0);
        check("rst_done",  32'(done_a), 32'd0);
        check("rst_count", 32'(cnt_a), 32'd0);
        check("rst_err",   32'(err_a), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_hold", 32'(hold_a), 32'd0);

        // T1: valid held high
        n0 = nwr_a;
        pulse_start(0);
        check("t1_busy",  32'(busy_a), 32'd1);
        check("t1_hold",  32'(hold_a), 32'd1);
        check("t1_ready", 32'(rdy_a), 32'd1);
        for (int i = 0; i < 8; i++) begin
            send_byte(0, S1[i], (i == 7), 0);
            if (i == 3) begin
                check("t1_lat_we", 32'(we_a), 32'd1);
                check("t1_lat_rdy", 32'(rdy_a), 32'd0);
                check("t1_lat_addr", 32'(addr_a), 32'd0);
                check("t1_lat_wdata", wdata_a, 32'h20080005);
            end
        end
        vld_a = 1'b0;
        wait_done(0);
        check("t1_im0",    im_a[0], 32'h20080005);
        check("t1_im1",    im_a[1], 32'h3C091234);
        check("t1_writes", 32'(nwr_a - n0), 32'd2);
        check("t1_count",  32'(cnt_a), 32'd2);
        check("t1_err",    32'(err_a), 32'd0);
        check("t1_hold",   32'(hold_a), 32'd0);
        check("t1_busy",   32'(busy_a), 32'd0);

        // T2: valid toggled every other cycle
        im_a[0] = '0;
        im_a[1] = '0;
        n0 = nwr_a;
        pulse_start(0);
        check("t2_count_clr", 32'(cnt_a), 32'd0);
        check("t2_done_clr",  32'(done_a), 32'd0);
        for (int i = 0; i < 8; i++) begin
            send_byte(0, S1[i], (i == 7), 1);
        end
        wait_done(0);
        check("t2_im0",    im_a[0], 32'h20080005);
        check("t2_im1",    im_a[1], 32'h3C091234);
        check("t2_writes", 32'(nwr_a - n0), 32'd2);
        check("t2_count",  32'(cnt_a), 32'd2);

        // T3: image ends off a word boundary
        pulse_start(0);
        for (int i = 0; i < 6; i++) begin
            send_byte(0, S3[i], (i == 5), 0);
        end
        vld_a = 1'b0;
        wait_done(0);
        check("t3_im0",   im_a[0], 32'h11223344);
        check("t3_im1",   im_a[1], 32'hAABB0000);
        check("t3_err",   32'(err_a), 32'd1);
        check("t3_count", 32'(cnt_a), 32'd2);

        // T6: start in DONE restarts; start in COLLECT is ignored
        pulse_start(0);
        check("t6_err_clr",   32'(err_a), 32'd0);
        check("t6_count_clr", 32'(cnt_a), 32'd0);
        send_byte(0, 8'h01, 0, 0);
        send_byte(0, 8'h02, 0, 0);
        vld_a = 1'b0;
        pulse_start(0);
        check("t6_still_busy", 32'(busy_a), 32'd1);
        send_byte(0, 8'h03, 0, 0);
        send_byte(0, 8'h04, 1, 0);
        vld_a = 1'b0;
        wait_done(0);
        check("t6_im0",   im_a[0], 32'h01020304);
        check("t6_count", 32'(cnt_a), 32'd1);
        check("t6_err",   32'(err_a), 32'd0);

        // T5: reset mid-word aborts without waiting for a clock edge
        pulse_start(0);
        for (int i = 0; i < 6; i++) begin
            send_byte(0, 8'(8'h50 + i), 0, 0);
        end
        vld_a = 1'b0;
        check("t5_pre_count", 32'(cnt_a), 32'd1);
        check("t5_pre_busy",  32'(busy_a), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_we",    32'(we_a), 32'd0);
        check("t5_busy",  32'(busy_a), 32'd0);
        check("t5_hold",  32'(hold_a), 32'd0);
        check("t5_count", 32'(cnt_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start(0);
        for (int i = 0; i < 4; i++) begin
            send_byte(0, 8'(8'h60 + i), 0, 0);
        end
        vld_a = 1'b0;
        check("t5_write_we", 32'(we_a), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_write_we_drop", 32'(we_a), 32'd0);
        check("t5_write_wdata",   wdata_a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start(0);
        send_byte(0, 8'hA1, 0, 0);
        send_byte(0, 8'hB2, 0, 0);
        send_byte(0, 8'hC3, 0, 0);
        send_byte(0, 8'hD4, 1, 0);
        vld_a = 1'b0;
        wait_done(0);
        check("t5_im0",   im_a[0], 32'hA1B2C3D4);
        check("t5_addr",  32'(last_addr_a), 32'd0);
        check("t5_count", 32'(cnt_a), 32'd1);

        // T4: 4-word memory overflows after 16 bytes
        n0 = nwr_b;
        pulse_start(1);
        for (int i = 0; i < 16; i++) begin
            send_byte(1, 8'(i + 1), 0, 0);
        end
        vld_b = 1'b0;
        wait_done(1);
        check("t4_writes", 32'(nwr_b - n0), 32'd4);
        check("t4_im0",    im_b[0], 32'h01020304);
        check("t4_im1",    im_b[1], 32'h05060708);
        check("t4_im2",    im_b[2], 32'h090A0B0C);
        check("t4_im3",    im_b[3], 32'h0D0E0F10);
        check("t4_err",    32'(err_b), 32'd1);
        check("t4_addr",   32'(addr_b), 32'd3);
        check("t4_count",  32'(cnt_b), 32'd4);
        rc = 0;
        for (int k = 0; k < 4; k++) begin
            bdata = 8'(17 + k);
            vld_b = 1'b1;
            repeat (3) begin
                @(negedge clk);
                if (rdy_b) rc++;
            end
        end
        vld_b = 1'b0;
        check("t4_ready_after", 32'(rc), 32'd0);
        check("t4_no_more_writes", 32'(nwr_b - n0), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
